// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU for the execute stage. Single-cycle logic ops,
//            add/sub and pass-B, plus an iterative shift-and-add unsigned
//            multiply. Result and NZCV flags are registered behind a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   ALUControl,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_PASS = 4'b0111;
  localparam logic [3:0] c_OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [N-1:0]   a_q, b_q, acc_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   result_q;
  logic           zero_q, neg_q, carry_q, ovf_q, done_q;

  logic [N-1:0]   w_res;
  logic           w_carry, w_ovf;
  logic [N:0]     w_sum, w_diff;
  logic           w_last_iter;

  assign w_last_iter = (cnt_q == CW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: MUL runs exactly N iterations, everything else goes straight to FIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (ALUControl == c_OP_MUL) ? S_MUL : S_FIN;
      S_MUL:  if (w_last_iter) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture and shift-and-add multiply datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        op_q  <= ALUControl;
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
        cnt_q <= '0;
      end
    end else if (state_q == S_MUL) begin
      if (a_q[0]) acc_q <= acc_q + b_q;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Final result and carry/overflow from the captured operands (or the MUL accumulator)
  always_comb begin
    w_sum   = {1'b0, a_q} + {1'b0, b_q};
    w_diff  = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op_q)
      c_OP_AND:  w_res = a_q & b_q;
      c_OP_OR:   w_res = a_q | b_q;
      c_OP_ADD: begin
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a_q[N-1] == b_q[N-1]) && (w_sum[N-1] != a_q[N-1]);
      end
      c_OP_SUB: begin
        w_res   = w_diff[N-1:0];
        w_carry = w_diff[N];
        w_ovf   = (a_q[N-1] != b_q[N-1]) && (w_diff[N-1] != a_q[N-1]);
      end
      c_OP_PASS: w_res = b_q;
      c_OP_MUL:  w_res = acc_q;
      default:   w_res = '0;
    endcase
  end

  // Output registers: written only in FIN, so they hold between completions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIN);
      if (state_q == S_FIN) begin
        result_q <= w_res;
        zero_q   <= (w_res == '0);
        neg_q    <= w_res[N-1];
        carry_q  <= w_carry;
        ovf_q    <= w_ovf;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed, table-driven bench for alu_mc (N = 64), with
//            hand-written sequences for reset, ignored start, back-to-back
//            issue and reset during a multiply.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   ALUControl;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [N-1:0] result;
  logic         zero, negative, carry, overflow;

  int checks = 0;
  int errors = 0;

  alu_mc #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [3:0]   nzcv;
    int           lat;   // edges after the sampling edge until done is seen
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; reports latency and busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] aa, input logic [N-1:0] bb,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; ALUControl = op; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    a = '1; b = '1; ALUControl = 4'b0001;   // scramble inputs: must not matter
    lat = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, stray;

    vecs[0]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1};
    vecs[1]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,                   4'b0110, 1};
    vecs[2]  = '{4'b0110, 64'd5,                   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1};
    vecs[3]  = '{4'b0110, 64'h1234,                64'h1234, 64'd0,                4'b0110, 1};
    vecs[4]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1};
    vecs[5]  = '{4'b1000, 64'h1_0000_0001,         64'h1_0000_0003, 64'h4_0000_0003, 4'b0000, 65};
    vecs[6]  = '{4'b1000, 64'h1_0000_0000,         64'h1_0000_0000, 64'd0,         4'b0100, 65};
    vecs[7]  = '{4'b1000, 64'd3,                   64'd5, 64'd15,                  4'b0000, 65};
    vecs[8]  = '{4'b0000, 64'hF0F0,                64'hFF00, 64'hF000,             4'b0000, 1};
    vecs[9]  = '{4'b0001, 64'hF0F0,                64'h0F0F, 64'hFFFF,             4'b0000, 1};
    vecs[10] = '{4'b0111, 64'h1111,                64'hABCD, 64'hABCD,             4'b0000, 1};
    vecs[11] = '{4'b0011, 64'h1234,                64'h5678, 64'd0,                4'b0100, 1};

    reset = 1'b1; start = 1'b0; ALUControl = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Get non-zero outputs, then reset mid-cycle and check they clear without a clock edge
    run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat, bcnt);
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs", {result, zero, negative, carry, overflow, busy, done}, '0);
    @(negedge clk) reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_nzcv", i), {negative, zero, carry, overflow}, vecs[i].nzcv);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
      chk($sformatf("v%0d_busy_in_done", i), busy, 1'b0);
    end

    // Ignored start while MUL is busy
    @(negedge clk);
    start = 1'b1; ALUControl = 4'b1000; a = 64'd3; b = 64'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; ALUControl = 4'b0000; a = '0; b = '0;
    @(posedge clk); #1 start = 1'b0;
    lat = 11;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("ign_latency", lat, 65);
    chk("ign_result", result, 64'd15);
    stray = 0;
    repeat (4) begin @(posedge clk); #1; if (done || busy) stray++; end
    chk("ign_no_extra_op", stray, 0);

    // Back-to-back: start in the done cycle is accepted
    run_op(4'b0111, 64'd0, 64'h1111, lat, bcnt);
    chk("b2b_first", result, 64'h1111);
    start = 1'b1; ALUControl = 4'b0111; a = '0; b = 64'hABCD;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_edges_after_done", lat, 2);
    chk("b2b_result", result, 64'hABCD);

    // Reset at iteration 30 of a MUL: no stray done, then a clean ADD
    @(negedge clk);
    start = 1'b1; ALUControl = 4'b1000; a = 64'd7; b = 64'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midmul_busy_cleared", busy, 1'b0);
    chk("midmul_result_cleared", result, 64'd0);
    @(negedge clk) reset = 1'b0;
    stray = 0;
    repeat (70) begin @(posedge clk); #1; if (done) stray++; end
    chk("midmul_no_stray_done", stray, 0);
    run_op(4'b0010, 64'd2, 64'd3, lat, bcnt);
    chk("post_reset_add", result, 64'd5);
    chk("post_reset_latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
